// File: rtl/udma_cfg_sequencer.sv
// udma_cfg_sequencer: table-driven master replaying programmed accesses on the uDMA config bus.
// Read-back compare of read entries is enabled by defining CFG_SEQ_READ_CHECK_EN.
module udma_cfg_sequencer #(
  parameter int N_CMDS = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DLY_W  = 8,
  parameter int IDX_W  = (N_CMDS > 1) ? $clog2(N_CMDS) : 1
) (
  input  logic              sys_clk_i,
  input  logic              rstn_i,
  input  logic              cmd_we_i,
  input  logic [IDX_W-1:0]  cmd_idx_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic              cmd_rwn_i,
  input  logic [DLY_W-1:0]  cmd_dly_i,
  input  logic [IDX_W:0]    cmd_cnt_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] cfg_addr_o,
  output logic [DATA_W-1:0] cfg_data_o,
  output logic              cfg_valid_o,
  output logic              cfg_rwn_o,
  input  logic              cfg_ready_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [IDX_W-1:0]  err_idx_o
);
  localparam logic [IDX_W:0] N_SAT = (IDX_W+1)'(N_CMDS);
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
`ifdef CFG_SEQ_READ_CHECK_EN
    RDCAP,
`endif
    DELAY,
    FIN
  } state_t;
  state_t state, state_d, post_cmd, post_hs;
  logic [ADDR_W-1:0] tbl_addr [N_CMDS];
  logic [DATA_W-1:0] tbl_data [N_CMDS];
  logic [DLY_W-1:0]  tbl_dly  [N_CMDS];
  logic              tbl_rwn  [N_CMDS];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    cnt_q;
  logic [DLY_W-1:0]  dly_cnt;
  logic go, hs, last, adv;
  assign go   = state == IDLE && start_i && !abort_i;
  assign hs   = cfg_valid_o && cfg_ready_i;
  assign last = {1'b0, idx} + (IDX_W+1)'(1) >= cnt_q;
  assign adv  = state_d == ISSUE && state != IDLE && (state != ISSUE || hs);
  assign post_cmd = (tbl_dly[idx] != '0) ? DELAY : last ? FIN : ISSUE;
`ifdef CFG_SEQ_READ_CHECK_EN
  assign post_hs = tbl_rwn[idx] ? RDCAP : post_cmd;
`else
  assign post_hs = post_cmd;
`endif
  assign busy_o      = state != IDLE;
  assign done_o      = state == FIN;
  assign cfg_valid_o = state == ISSUE && cnt_q != '0;
  assign cfg_addr_o  = cfg_valid_o ? tbl_addr[idx] : '0;
  assign cfg_data_o  = cfg_valid_o ? tbl_data[idx] : '0;
  assign cfg_rwn_o   = cfg_valid_o ? tbl_rwn[idx] : 1'b1;
  always_ff @(posedge sys_clk_i or negedge rstn_i)
    if (!rstn_i) begin
      for (int i = 0; i < N_CMDS; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
        tbl_dly[i]  <= '0;
        tbl_rwn[i]  <= 1'b0;
      end
    end else if (cmd_we_i && !busy_o && {1'b0, cmd_idx_i} < N_SAT) begin
      tbl_addr[cmd_idx_i] <= cmd_addr_i;
      tbl_data[cmd_idx_i] <= cmd_data_i;
      tbl_dly[cmd_idx_i]  <= cmd_dly_i;
      tbl_rwn[cmd_idx_i]  <= cmd_rwn_i;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start_i ? ISSUE : IDLE;
      ISSUE:   state_d = (cnt_q == '0) ? FIN : hs ? post_hs : ISSUE;
`ifdef CFG_SEQ_READ_CHECK_EN
      RDCAP:   state_d = post_cmd;
`endif
      DELAY:   state_d = (dly_cnt > DLY_W'(1)) ? DELAY : last ? FIN : ISSUE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end
  always_ff @(posedge sys_clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state   <= IDLE;
      idx     <= '0;
      cnt_q   <= '0;
      dly_cnt <= '0;
    end else begin
      state <= state_d;
      if (go) begin
        idx   <= '0;
        cnt_q <= (cmd_cnt_i > N_SAT) ? N_SAT : cmd_cnt_i;
      end
      if (adv) idx <= idx + 1'b1;
      dly_cnt <= (state_d != DELAY) ? '0 : (state == DELAY) ? dly_cnt - 1'b1 : tbl_dly[idx];
    end
`ifdef CFG_SEQ_READ_CHECK_EN
  logic             err_q;
  logic [IDX_W-1:0] err_idx_q;
  // read data arrives the cycle after the handshake, i.e. while in RDCAP
  always_ff @(posedge sys_clk_i or negedge rstn_i)
    if (!rstn_i) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (go) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (state == RDCAP && !abort_i && cfg_data_i != tbl_data[idx]) begin
      err_q <= 1'b1;
      if (!err_q) err_idx_q <= idx;
    end
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^cfg_data_i;
  assign err_o        = 1'b0;
  assign err_idx_o    = '0;
`endif
endmodule

// File: tb/tb_udma_cfg_sequencer.sv
// tb_udma_cfg_sequencer: directed checks of the config-bus sequencer with hand-computed expectations.
module tb_udma_cfg_sequencer;
  logic        sys_clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cmd_we_i = 1'b0;
  logic [2:0]  cmd_idx_i = '0;
  logic [4:0]  cmd_addr_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic        cmd_rwn_i = 1'b0;
  logic [7:0]  cmd_dly_i = '0;
  logic [3:0]  cmd_cnt_i = '0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic        cfg_ready_i = 1'b0;
  logic [31:0] cfg_data_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  err_idx_o;
  int checks = 0, failures = 0, hs_cnt = 0, done_cnt = 0;

  udma_cfg_sequencer dut (
    .sys_clk_i(sys_clk_i), .rstn_i(rstn_i),
    .cmd_we_i(cmd_we_i), .cmd_idx_i(cmd_idx_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .cmd_rwn_i(cmd_rwn_i), .cmd_dly_i(cmd_dly_i), .cmd_cnt_i(cmd_cnt_i),
    .start_i(start_i), .abort_i(abort_i),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_ready_i(cfg_ready_i), .cfg_data_i(cfg_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_idx_o(err_idx_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  always @(posedge sys_clk_i) begin
    if (cfg_valid_o && cfg_ready_i) hs_cnt++;
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk_i);
      #1;
    end
  endtask

  task automatic load(input int i, input logic rwn, input logic [4:0] a, input logic [31:0] d, input logic [7:0] dly);
    cmd_idx_i = 3'(i); cmd_rwn_i = rwn; cmd_addr_i = a; cmd_data_i = d; cmd_dly_i = dly;
    cmd_we_i = 1'b1;
    tick();
    cmd_we_i = 1'b0;
  endtask

  task automatic run(input logic [3:0] cnt);
    cmd_cnt_i = cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    logic [9:0] vpat, dpat, bpat;
    logic [4:0] a6;
    int h0, d0;
    #12;
    check("rst_valid", cfg_valid_o, 0);
    check("rst_rwn", cfg_rwn_o, 1);
    check("rst_busy_done_err", {busy_o, done_o, err_o, err_idx_o}, 0);
    check("rst_addr_data", {cfg_addr_o, cfg_data_o}, 0);
    @(posedge sys_clk_i); #1;
    rstn_i = 1'b1;
    tick();

    // single UART setup write
    cfg_ready_i = 1'b1;
    load(0, 1'b0, 5'h09, 32'h01B10308, 8'd0);
    run(4'd1);
    check("t1_c1_valid_busy", {cfg_valid_o, busy_o, cfg_rwn_o}, 3'b110);
    check("t1_c1_addr", cfg_addr_o, 5'h09);
    check("t1_c1_data", cfg_data_o, 32'h01B10308);
    tick();
    check("t1_c2_done", {done_o, busy_o, cfg_valid_o, cfg_rwn_o}, 4'b1101);
    check("t1_c2_data", cfg_data_o, 0);
    tick();
    check("t1_c3_idle", {done_o, busy_o}, 0);

    // three writes, delays {0,3,0}
    load(0, 1'b0, 5'h01, 32'h11, 8'd0);
    load(1, 1'b0, 5'h02, 32'h22, 8'd3);
    load(2, 1'b0, 5'h03, 32'h33, 8'd0);
    vpat = '0; dpat = '0; bpat = '0; a6 = '0;
    run(4'd3);
    for (int c = 1; c <= 9; c++) begin
      vpat[c] = cfg_valid_o;
      dpat[c] = done_o;
      bpat[c] = busy_o;
      if (c == 6) a6 = cfg_addr_o;
      tick();
    end
    check("t2_valid_pattern", vpat, 10'h046);
    check("t2_done_pattern", dpat, 10'h080);
    check("t2_busy_pattern", bpat, 10'h0FE);
    check("t2_c6_addr", a6, 5'h03);

    // ready held low five cycles
    load(0, 1'b0, 5'h05, 32'hDEADBEEF, 8'd0);
    cfg_ready_i = 1'b0;
    h0 = hs_cnt;
    run(4'd1);
    for (int c = 0; c < 5; c++) begin
      check("t3_stall_hold", {cfg_valid_o, cfg_addr_o, cfg_data_o}, {1'b1, 5'h05, 32'hDEADBEEF});
      tick();
    end
    check("t3_no_hs_yet", hs_cnt - h0, 0);
    cfg_ready_i = 1'b1;
    tick();
    check("t3_single_hs", hs_cnt - h0, 1);
    check("t3_done", done_o, 1);
    tick();

    // read entry, bus returns a different value
    load(0, 1'b1, 5'h00, 32'hA5, 8'd0);
    cfg_data_i = 32'h5A;
    run(4'd1);
    check("t4_read_issue", {cfg_valid_o, cfg_rwn_o, cfg_addr_o}, {2'b11, 5'h00});
`ifdef CFG_SEQ_READ_CHECK_EN
    tick();
    check("t4_rdcap_no_done", done_o, 0);
    tick();
    check("t4_done_err", {done_o, err_o, err_idx_o}, {2'b11, 3'd0});
    tick();
    cfg_data_i = 32'hA5;
    run(4'd1);
    check("t4_err_cleared", err_o, 0);
    tick(3);
    check("t4_clean_end", {busy_o, err_o}, 0);
`else
    tick();
    check("t4_done_err", {done_o, err_o, err_idx_o}, {2'b10, 3'd0});
    tick();
`endif

    // count above depth saturates to eight entries
    for (int i = 0; i < 8; i++) load(i, 1'b0, 5'(i + 1), 32'(i), 8'd0);
    h0 = hs_cnt;
    run(4'd15);
    tick(8);
    check("t5_sat_hs", hs_cnt - h0, 8);
    check("t5_sat_done", done_o, 1);
    tick();
    check("t5_sat_idle", busy_o, 0);

    // abort during the delay of entry 1 of 4
    load(1, 1'b0, 5'h02, 32'h2, 8'd4);
    h0 = hs_cnt; d0 = done_cnt;
    run(4'd4);
    tick(2);
    check("t6_in_delay", {busy_o, cfg_valid_o}, 2'b10);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t6_aborted", {busy_o, cfg_valid_o}, 0);
    tick(8);
    check("t6_after_abort", {hs_cnt - h0, done_cnt - d0}, {32'd2, 32'd0});

    // zero count: done only
    h0 = hs_cnt;
    run(4'd0);
    check("t7_c1", {cfg_valid_o, busy_o, done_o}, 3'b010);
    tick();
    check("t7_c2_done", done_o, 1);
    tick();
    check("t7_no_traffic", {busy_o, 32'(hs_cnt - h0)}, 0);

    // start with abort in idle: abort wins
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("t8_abort_wins", busy_o, 0);

    // table write and start in the same cycle
    cmd_idx_i = 3'd0; cmd_rwn_i = 1'b0; cmd_addr_i = 5'h1F; cmd_data_i = 32'h12345678; cmd_dly_i = 8'd0;
    cmd_we_i = 1'b1;
    run(4'd1);
    cmd_we_i = 1'b0;
    check("t9_new_entry", {cfg_valid_o, cfg_addr_o, cfg_data_o}, {1'b1, 5'h1F, 32'h12345678});
    tick(2);

    // start and table write while busy are ignored
    load(0, 1'b0, 5'h04, 32'h44, 8'd5);
    d0 = done_cnt;
    run(4'd1);
    tick();
    start_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 5'h1A;
    tick();
    start_i = 1'b0; cmd_we_i = 1'b0;
    tick(4);
    check("t10_done_c7", done_o, 1);
    tick();
    check("t10_idle", {busy_o, 32'(done_cnt - d0)}, {1'b0, 32'd1});
    run(4'd1);
    check("t10_entry_kept", cfg_addr_o, 5'h04);
    tick(8);

    // async reset mid-issue zeroes outputs and table
    load(0, 1'b0, 5'h07, 32'hCAFE, 8'd0);
    cfg_ready_i = 1'b0;
    d0 = done_cnt;
    run(4'd1);
    check("t11_pre_rst_valid", cfg_valid_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    check("t11_async_outs", {cfg_valid_o, busy_o, done_o, cfg_addr_o, cfg_data_o}, 0);
    check("t11_async_rwn", cfg_rwn_o, 1);
    @(posedge sys_clk_i); #1;
    rstn_i = 1'b1;
    cfg_ready_i = 1'b1;
    run(4'd1);
    check("t11_table_zeroed", {cfg_valid_o, cfg_addr_o, cfg_data_o}, {1'b1, 37'd0});
    tick();
    check("t11_done_once", {done_o, 32'(done_cnt - d0)}, {1'b1, 32'd0});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
